// File: rtl/vdp_mem_pkg.sv
// Shared memory-subsystem types: requester port ids, the SDRAM command slot
// layout and the arbiter lock states.
package vdp_mem_pkg;

    localparam int PORT_DISPLAY = 0;
    localparam int PORT_DRAW    = 1;
    localparam int PORT_CPU     = 2;

    localparam int MEM_NREQ = 3;
    localparam int MEM_AW   = 24;
    localparam int MEM_DW   = 16;
    localparam int MEM_MW   = 2;
    localparam int MEM_TW   = $clog2(MEM_NREQ);

    typedef struct packed {
        logic              we;
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] wdata;
        logic [MEM_MW-1:0] wmask;
        logic [MEM_TW-1:0] tag;
    } mem_cmd_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } arb_state_e;

    // Index of the highest set bit; callers pass a one-hot vector.
    function automatic int onehot_idx(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/sdram_arbiter_rr_pick.sv
// Combinational one-hot round-robin picker: the first requester at or after
// the start index (wrapping) wins.
module rr_pick #(
    parameter  int W  = 2,
    localparam int PW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req,
    input  logic [PW-1:0] start,
    output logic [W-1:0]  grant,
    output logic          grant_valid
);

    // Scan offsets from farthest to nearest so the nearest hit is the final write.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int k = W - 1; k >= 0; k--) begin
            if (req[(int'(start) + k) % W]) begin
                grant                          = '0;
                grant[(int'(start) + k) % W]   = 1'b1;
                grant_valid                    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates the SDRAM controller command port between display, draw and CPU
// requesters and routes tagged read data back to the issuing port.
module sdram_arbiter
    import vdp_mem_pkg::*;
#(
    parameter int NREQ     = MEM_NREQ,
    parameter int AW       = MEM_AW,
    parameter int DW       = MEM_DW,
    parameter int MW       = MEM_MW,
    parameter int MAX_WAIT = 64,
    parameter int MAX_HOLD = 8,
    parameter int TW       = $clog2(NREQ)
) (
    input  logic             clk_draw,
    input  logic             initial_rst_signal,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [NREQ-1:0]  req_we,
    input  logic [NREQ-1:0]  req_hold,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    input  logic [NREQ*MW-1:0] req_wmask,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic             cmd_we,
    output logic [AW-1:0]    cmd_addr,
    output logic [DW-1:0]    cmd_wdata,
    output logic [MW-1:0]    cmd_wmask,
    output logic [TW-1:0]    cmd_tag,
    input  logic             ctl_rvalid,
    input  logic [DW-1:0]    ctl_rdata,
    input  logic [TW-1:0]    ctl_rtag,
    output logic [NREQ-1:0]  rsp_valid,
    output logic [DW-1:0]    rsp_data,
    output logic [TW-1:0]    grant_owner
);

    localparam int RW  = NREQ - 1;
    localparam int RPW = (RW > 1) ? $clog2(RW) : 1;
    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam int HCW = $clog2(MAX_HOLD + 1);

    mem_cmd_t        cmd_reg, cmd_load;
    logic            cmd_valid_reg;
    arb_state_e      state_reg, state_next;
    logic [TW-1:0]   owner_reg, owner_next;
    logic [HCW-1:0]  hold_cnt_reg, hold_cnt_next;
    logic [TW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [TW-1:0]   grant_owner_reg;
    logic [NREQ-1:0] rsp_valid_reg;
    logic [DW-1:0]   rsp_data_reg;

    logic            acc_ok, owner_active, sel_valid, from_rr;
    logic [TW-1:0]   sel_idx;
    logic [NREQ-1:1] starved;
    logic [RW-1:0]   rr_grant;
    logic            rr_valid;
    logic [RPW-1:0]  rr_start;

    assign acc_ok       = !cmd_valid_reg || cmd_ready;
    assign owner_active = (state_reg == LOCKED) && req_valid[owner_reg];

    // Starvation counters exist only for the round-robin ports.
    genvar gi;
    for (gi = 1; gi < NREQ; gi++) begin : g_wait
        logic [WCW-1:0] wait_cnt_reg;
        always_ff @(posedge clk_draw or posedge initial_rst_signal) begin
            if (initial_rst_signal)
                wait_cnt_reg <= '0;
            else if (!req_valid[gi] || req_ready[gi])
                wait_cnt_reg <= '0;
            else if (wait_cnt_reg != WCW'(MAX_WAIT))
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
        assign starved[gi] = req_valid[gi] && (wait_cnt_reg == WCW'(MAX_WAIT));
    end

    assign rr_start = RPW'(rr_ptr_reg - 1'b1);

    rr_pick #(.W(RW)) u_rr_pick (
        .req         (req_valid[NREQ-1:1]),
        .start       (rr_start),
        .grant       (rr_grant),
        .grant_valid (rr_valid)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        from_rr   = 1'b0;
        if (acc_ok) begin
            if (owner_active) begin
                sel_valid = 1'b1;
                sel_idx   = owner_reg;
            end else if (|starved) begin
                sel_valid = 1'b1;
                for (int i = NREQ - 1; i >= 1; i--) begin
                    if (starved[i]) sel_idx = TW'(i);
                end
            end else if (req_valid[PORT_DISPLAY]) begin
                sel_valid = 1'b1;
                sel_idx   = TW'(PORT_DISPLAY);
            end else if (rr_valid) begin
                sel_valid = 1'b1;
                from_rr   = 1'b1;
                sel_idx   = TW'(onehot_idx(32'(rr_grant)) + 1);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (sel_valid && !initial_rst_signal) req_ready[sel_idx] = 1'b1;
    end

    always_comb begin
        cmd_load.we    = req_we[sel_idx];
        cmd_load.addr  = req_addr[sel_idx*AW +: AW];
        cmd_load.wdata = req_wdata[sel_idx*DW +: DW];
        cmd_load.wmask = req_wmask[sel_idx*MW +: MW];
        cmd_load.tag   = sel_idx;
    end

    // An idle owner releases first, so the same cycle can grant and lock someone else.
    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        hold_cnt_next = hold_cnt_reg;
        rr_ptr_next   = rr_ptr_reg;
        if ((state_reg == LOCKED) && acc_ok && !req_valid[owner_reg]) begin
            state_next    = UNLOCKED;
            hold_cnt_next = '0;
        end
        if (sel_valid) begin
            if (owner_active) begin
                hold_cnt_next = hold_cnt_reg + 1'b1;
                if (!req_hold[sel_idx] || (hold_cnt_reg >= HCW'(MAX_HOLD - 1))) begin
                    state_next    = UNLOCKED;
                    hold_cnt_next = '0;
                end
            end else if (req_hold[sel_idx]) begin
                state_next    = LOCKED;
                owner_next    = sel_idx;
                hold_cnt_next = HCW'(1);
            end
            if (from_rr)
                rr_ptr_next = (sel_idx == TW'(NREQ - 1)) ? TW'(1) : sel_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_draw or posedge initial_rst_signal) begin
        if (initial_rst_signal) begin
            state_reg       <= UNLOCKED;
            owner_reg       <= '0;
            hold_cnt_reg    <= '0;
            rr_ptr_reg      <= TW'(1);
            cmd_reg         <= '0;
            cmd_valid_reg   <= 1'b0;
            grant_owner_reg <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            hold_cnt_reg <= hold_cnt_next;
            rr_ptr_reg   <= rr_ptr_next;
            if (sel_valid) begin
                cmd_reg         <= cmd_load;
                cmd_valid_reg   <= 1'b1;
                grant_owner_reg <= sel_idx;
            end else if (cmd_ready) begin
                cmd_valid_reg <= 1'b0;
            end
        end
    end

    for (gi = 0; gi < NREQ; gi++) begin : g_rsp
        always_ff @(posedge clk_draw or posedge initial_rst_signal) begin
            if (initial_rst_signal)
                rsp_valid_reg[gi] <= 1'b0;
            else
                rsp_valid_reg[gi] <= ctl_rvalid && (ctl_rtag == TW'(gi));
        end
    end

    always_ff @(posedge clk_draw or posedge initial_rst_signal) begin
        if (initial_rst_signal)
            rsp_data_reg <= '0;
        else if (ctl_rvalid)
            rsp_data_reg <= ctl_rdata;
    end

    assign cmd_valid   = cmd_valid_reg;
    assign cmd_we      = cmd_reg.we;
    assign cmd_addr    = cmd_reg.addr;
    assign cmd_wdata   = cmd_reg.wdata;
    assign cmd_wmask   = cmd_reg.wmask;
    assign cmd_tag     = cmd_reg.tag;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_data    = rsp_data_reg;
    assign grant_owner = grant_owner_reg;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: expected commands are queued when a grant
// is expected and compared when the command slot hands off to the controller.
module tb_sdram_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 24;
    localparam int DW   = 16;
    localparam int MW   = 2;
    localparam int TW   = 2;

    logic              clk_draw = 1'b0;
    logic              initial_rst_signal = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_we = '0;
    logic [NREQ-1:0]   req_hold = '0;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ*MW-1:0] req_wmask;
    logic              cmd_valid;
    logic              cmd_ready = 1'b1;
    logic              cmd_we;
    logic [AW-1:0]     cmd_addr;
    logic [DW-1:0]     cmd_wdata;
    logic [MW-1:0]     cmd_wmask;
    logic [TW-1:0]     cmd_tag;
    logic              ctl_rvalid = 1'b0;
    logic [DW-1:0]     ctl_rdata = '0;
    logic [TW-1:0]     ctl_rtag = '0;
    logic [NREQ-1:0]   rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic [TW-1:0]     grant_owner;

    logic [AW-1:0] p_addr  [NREQ];
    logic [DW-1:0] p_wdata [NREQ];
    logic [MW-1:0] p_mask  [NREQ];

    genvar gi;
    for (gi = 0; gi < NREQ; gi++) begin : g_pack
        assign req_addr[gi*AW +: AW]  = p_addr[gi];
        assign req_wdata[gi*DW +: DW] = p_wdata[gi];
        assign req_wmask[gi*MW +: MW] = p_mask[gi];
    end

    always #5 clk_draw = ~clk_draw;

    sdram_arbiter dut (
        .clk_draw           (clk_draw),
        .initial_rst_signal (initial_rst_signal),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_we             (req_we),
        .req_hold           (req_hold),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .req_wmask          (req_wmask),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_we             (cmd_we),
        .cmd_addr           (cmd_addr),
        .cmd_wdata          (cmd_wdata),
        .cmd_wmask          (cmd_wmask),
        .cmd_tag            (cmd_tag),
        .ctl_rvalid         (ctl_rvalid),
        .ctl_rdata          (ctl_rdata),
        .ctl_rtag           (ctl_rtag),
        .rsp_valid          (rsp_valid),
        .rsp_data           (rsp_data),
        .grant_owner        (grant_owner)
    );

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
    } exp_cmd_t;

    exp_cmd_t exp_q[$];
    int       checks_total  = 0;
    int       checks_passed = 0;
    logic     exp_cmd_valid = 1'b0;
    int       exp_rr        = 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_ports(input int base);
        for (int i = 0; i < NREQ; i++) begin
            p_addr[i]  = AW'(i * 24'h010000 + base);
            p_wdata[i] = DW'(base * 7 + i * 16'h1111);
            p_mask[i]  = MW'(i + base);
        end
    endtask

    // One cycle: inputs are already driven at posedge+1; sample at posedge-2.
    task automatic step(input int exp_port, input string name);
        exp_cmd_t        e;
        logic [NREQ-1:0] exp_rdy;
        #7;
        exp_rdy = (exp_port >= 0) ? NREQ'(1 << exp_port) : '0;
        chk({name, " req_ready"}, 64'(req_ready), 64'(exp_rdy));
        chk({name, " cmd_valid"}, 64'(cmd_valid), 64'(exp_cmd_valid));
        if (cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                chk({name, " unexpected cmd"}, 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk({name, " cmd_tag"},   64'(cmd_tag),   64'(e.tag));
                chk({name, " cmd_addr"},  64'(cmd_addr),  64'(e.addr));
                chk({name, " cmd_we"},    64'(cmd_we),    64'(e.we));
                chk({name, " cmd_wdata"}, 64'(cmd_wdata), 64'(e.wdata));
                chk({name, " cmd_wmask"}, 64'(cmd_wmask), 64'(e.wmask));
                $display("cmd %s tag=%0d addr=%06h", name, cmd_tag, cmd_addr);
            end
        end
        if (exp_port >= 0) begin
            e.tag   = TW'(exp_port);
            e.addr  = p_addr[exp_port];
            e.we    = req_we[exp_port];
            e.wdata = p_wdata[exp_port];
            e.wmask = p_mask[exp_port];
            exp_q.push_back(e);
            exp_cmd_valid = 1'b1;
        end else if (cmd_ready) begin
            exp_cmd_valid = 1'b0;
        end
        @(posedge clk_draw);
        #1;
    endtask

    task automatic rsp_check(input string name, input logic [NREQ-1:0] ev, input logic [DW-1:0] ed);
        #7;
        chk({name, " rsp_valid"}, 64'(rsp_valid), 64'(ev));
        chk({name, " rsp_data"},  64'(rsp_data),  64'(ed));
        $display("rsp %s valid=%b data=%04h", name, rsp_valid, rsp_data);
        @(posedge clk_draw);
        #1;
    endtask

    initial begin
        set_ports(16'h0100);
        req_valid = 3'b111;
        #12;
        chk("rst req_ready",   64'(req_ready),   64'd0);
        chk("rst cmd_valid",   64'(cmd_valid),   64'd0);
        chk("rst rsp_valid",   64'(rsp_valid),   64'd0);
        chk("rst rsp_data",    64'(rsp_data),    64'd0);
        chk("rst grant_owner", 64'(grant_owner), 64'd0);
        chk("rst cmd_tag",     64'(cmd_tag),     64'd0);
        @(posedge clk_draw);
        #1;
        initial_rst_signal = 1'b0;

        // Reset release and fixed priority
        step(0, "first_all_valid");
        req_valid = 3'b011;
        step(0, "prio_p0_over_p1");
        req_valid = 3'b010;
        step(1, "p1_after_p0_drops");
        exp_rr = 2;
        req_valid = 3'b000;
        step(-1, "prio_drain");

        // Round-robin between ports 1 and 2
        set_ports(16'h0200);
        req_valid = 3'b110;
        for (int i = 0; i < 6; i++) begin
            step(exp_rr, "rr");
            exp_rr = (exp_rr == NREQ - 1) ? 1 : exp_rr + 1;
        end
        req_valid = 3'b000;
        step(-1, "rr_drain");

        // Starvation: port 1 wins once its wait count saturates
        set_ports(16'h0300);
        req_valid = 3'b011;
        for (int i = 0; i < 64; i++) step(0, "starve_p0");
        step(1, "starve_p1");
        step(0, "starve_p0_resume");
        step(0, "starve_p0_resume2");
        req_valid = 3'b000;
        step(-1, "starve_drain");

        // Hold: port 2 locks for MAX_HOLD accepts despite port 0
        set_ports(16'h0400);
        req_we    = 3'b100;
        req_hold  = 3'b100;
        req_valid = 3'b100;
        step(2, "hold_first");
        req_valid = 3'b101;
        for (int i = 0; i < 7; i++) step(2, "hold_locked");
        step(0, "hold_release_p0");
        req_valid = 3'b000;
        req_hold  = 3'b000;
        step(-1, "hold_drain");

        // Backpressure keeps the slot stable and blocks grants
        set_ports(16'h0500);
        req_we    = 3'b010;
        req_valid = 3'b010;
        step(1, "bp_load");
        cmd_ready = 1'b0;
        req_valid = 3'b101;
        set_ports(16'h0600);
        for (int i = 0; i < 5; i++) begin
            step(-1, "bp_stall");
            chk("bp stable tag",   64'(cmd_tag),   64'(exp_q[0].tag));
            chk("bp stable addr",  64'(cmd_addr),  64'(exp_q[0].addr));
            chk("bp stable wdata", 64'(cmd_wdata), 64'(exp_q[0].wdata));
        end
        cmd_ready = 1'b1;
        step(0, "bp_resume");
        req_valid = 3'b100;
        step(2, "bp_p2");
        req_valid = 3'b000;
        step(-1, "bp_drain");
        step(-1, "bp_idle");
        chk("grant_owner last", 64'(grant_owner), 64'd2);

        // Read return routing
        ctl_rvalid = 1'b1;
        ctl_rtag   = 2'd2;
        ctl_rdata  = 16'hBEEF;
        step(-1, "rd_issue2");
        ctl_rvalid = 1'b0;
        ctl_rdata  = 16'h0000;
        rsp_check("rd_tag2", 3'b100, 16'hBEEF);
        rsp_check("rd_hold", 3'b000, 16'hBEEF);
        ctl_rvalid = 1'b1;
        ctl_rtag   = 2'd1;
        ctl_rdata  = 16'h5A5A;
        step(-1, "rd_issue1");
        ctl_rvalid = 1'b1;
        ctl_rtag   = 2'd3;
        ctl_rdata  = 16'h1234;
        rsp_check("rd_tag1", 3'b010, 16'h5A5A);
        ctl_rvalid = 1'b0;
        rsp_check("rd_badtag", 3'b000, 16'h1234);

        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
